aes_128_iter: RTL and testbench

Iterative, parameterised AES-128 encryption core with valid/ready handshakes on both sides. Instead of one fully unrolled ten-stage pipeline, it applies UNROLL rounds per clock to a single block held in a round register. This trades throughput for area and adds backpressure, result holding and reset behaviour. It sits in the same datapath slot as the pipelined core: plaintext and key in, ciphertext out. Upstream and downstream logic must now honour the handshakes.

---
 rtl/aes_128_iter_if.sv | 22 ++
 rtl/aes_128_iter.sv | 142 ++++++++++++++
 tb/tb_aes_128_iter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/aes_128_iter_if.sv
// Handshake bundle for the iterative AES-128 core: plaintext/key in, ciphertext out.
// The master side drives the block and the consumer ready; the slave side is the core.
interface aes_128_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
  logic         busy;

  modport master (
    output in_valid, state, key, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, state, key, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/aes_128_iter.sv
// Iterative AES-128 encryptor: UNROLL chained rounds per clock on one block held in
// a round register, with valid/ready on both sides and a held result register.
module aes_128_iter #(
  parameter int UNROLL = 1
) (
  input logic          clk,
  input logic          rst_n,
  aes_128_iter_if.slave bus
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
      $error("aes_128_iter: UNROLL must be 1, 2, 5 or 10");
    end
  endgenerate

  // Byte x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t ^ {r, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Column-major bytes: index r + 4c; ShiftRows pulls row r from column (c + r) mod 4.
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last_rnd);
    logic [127:0] sr, mc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
    return (last_rnd ? sr : mc) ^ rk;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         st_q, st_d;
  logic [127:0] s_q, k_q, res_q;
  logic [7:0]   rc_q;
  logic [3:0]   rnd_q;
  logic         accept, last;

  logic [127:0] s_c  [UNROLL+1];
  logic [127:0] k_c  [UNROLL+1];
  logic [7:0]   rc_c [UNROLL+1];

  assign s_c[0]  = s_q;
  assign k_c[0]  = k_q;
  assign rc_c[0] = rc_q;

  generate
    for (genvar j = 0; j < UNROLL; j++) begin : g_slice
      assign k_c[j+1]  = next_key(k_c[j], rc_c[j]);
      assign rc_c[j+1] = xtime(rc_c[j]);
      assign s_c[j+1]  = enc_round(s_c[j], k_c[j+1], (rnd_q + 4'(j + 1)) == 4'd10);
    end
  endgenerate

  assign last         = (rnd_q + 4'(UNROLL)) == 4'd10;
  // in_ready sees only FSM state and out_ready, never in_valid.
  assign bus.in_ready = (st_q == IDLE) || (st_q == DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: st_d takes its hold value first so every path assigns it and no latch is inferred.
    st_d = st_q;
    case (st_q)
      IDLE:    if (accept) st_d = RUN;
      RUN:     if (last) st_d = DONE;
      DONE:    if (bus.out_ready) st_d = accept ? RUN : IDLE;
      default: st_d = IDLE;
    endcase
  end

  // NOTE: every register, res included, is cleared by rst_n so an aborted block never surfaces on out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      s_q   <= '0;
      k_q   <= '0;
      rc_q  <= '0;
      rnd_q <= '0;
      res_q <= '0;
    end else begin
      // NOTE: non-blocking updates make s, k, rc and rnd all sample the pre-edge round values.
      st_q <= st_d;
      if (accept) begin
        s_q   <= bus.state ^ bus.key;
        k_q   <= bus.key;
        rc_q  <= 8'h01;
        rnd_q <= '0;
      end else if (st_q == RUN) begin
        s_q   <= s_c[UNROLL];
        k_q   <= k_c[UNROLL];
        rc_q  <= rc_c[UNROLL];
        rnd_q <= rnd_q + 4'(UNROLL);
        if (last) res_q <= s_c[UNROLL];
      end
    end
  end

  assign bus.out_valid = (st_q == DONE);
  assign bus.out       = res_q;
  assign bus.busy      = (st_q != IDLE);

endmodule

// File: tb/tb_aes_128_iter.sv
// Directed bench for aes_128_iter: FIPS-197 vectors, back-to-back streaming,
// backpressure and asynchronous reset mid-block, with a queue of expected ciphertexts.
module tb_aes_128_iter;
  parameter int UNROLL = 1;
  localparam int LAT = 10 / UNROLL;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_128_iter_if bus ();
  aes_128_iter #(.UNROLL(UNROLL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, n_acc = 0, n_out = 0;
  int acc_cyc = -1, acc_prev = -1, out_cyc = -1, rise_cyc = -1;
  logic         ov_prev = 1'b0;
  logic [127:0] pend_exp = '0;
  logic [127:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [127:0] st, input logic [127:0] ky, input logic [127:0] ex);
    bus.state    = st;
    bus.key      = ky;
    pend_exp     = ex;
    bus.in_valid = 1'b1;
  endtask

  // One clock: evaluate handshakes mid-cycle, then advance to the next falling edge.
  task automatic step();
    logic         fin, fout;
    logic [127:0] ex;
    #1;
    fin  = bus.in_valid && bus.in_ready;
    fout = bus.out_valid && bus.out_ready;
    if (bus.out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = bus.out_valid;
    if (fout) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 128'(exp_q.size()), 128'd1);
      end else begin
        ex = exp_q.pop_front();
        check("out", bus.out, ex);
      end
      out_cyc = cyc;
      n_out++;
    end
    if (fin) begin
      exp_q.push_back(pend_exp);
      acc_prev = acc_cyc;
      acc_cyc  = cyc;
      n_acc++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_acc();
    int start = n_acc;
    for (int i = 0; i < 50 && n_acc == start; i++) step();
    check("accept_timeout", 128'(n_acc != start), 128'd1);
  endtask

  task automatic wait_out();
    int start = n_out;
    for (int i = 0; i < 50 && n_out == start; i++) step();
    check("output_timeout", 128'(n_out != start), 128'd1);
  endtask

  initial begin
    int saved_acc;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.state     = '0;
    bus.key       = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out", bus.out, 128'h0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 C.1 with exact latency.
    bus.out_ready = 1'b1;
    drive(C1_PT, C1_KEY, C1_CT);
    wait_acc();
    bus.in_valid = 1'b0;
    #1;
    check("run_busy", 128'(bus.busy), 128'd1);
    check("run_in_ready", 128'(bus.in_ready), 128'd0);
    check("run_out_valid", 128'(bus.out_valid), 128'd0);
    wait_out();
    check("c1_latency", 128'(rise_cyc - acc_cyc), 128'(LAT + 1));

    // Appendix B, then all-zero key and block.
    drive(B_PT, B_KEY, B_CT);
    wait_acc();
    bus.in_valid = 1'b0;
    wait_out();
    drive(128'h0, 128'h0, Z_CT);
    wait_acc();
    bus.in_valid = 1'b0;
    wait_out();

    // Back-to-back with in_valid and out_ready held high.
    drive(B_PT, B_KEY, B_CT);
    wait_acc();
    drive(128'h0, 128'h0, Z_CT);
    wait_acc();
    check("b2b_accept_in_done", 128'(acc_cyc), 128'(out_cyc));
    check("b2b_period", 128'(acc_cyc - acc_prev), 128'(LAT + 1));
    bus.in_valid = 1'b0;
    wait_out();
    check("b2b_queue_empty", 128'(exp_q.size()), 128'd0);

    // Backpressure: result held for 20 cycles, in_valid pulse refused.
    bus.out_ready = 1'b0;
    drive(C1_PT, C1_KEY, C1_CT);
    wait_acc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && !bus.out_valid; i++) step();
    check("bp_done_timeout", 128'(bus.out_valid), 128'd1);
    saved_acc = n_acc;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) drive(B_PT, B_KEY, B_CT);
      else bus.in_valid = 1'b0;
      #1;
      check("bp_out", bus.out, C1_CT);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      step();
    end
    check("bp_no_accept", 128'(n_acc), 128'(saved_acc));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    #1;
    check("bp_idle_busy", 128'(bus.busy), 128'd0);
    check("bp_idle_in_ready", 128'(bus.in_ready), 128'd1);

    // Asynchronous reset mid-RUN, then a clean C.1.
    drive(C1_PT, C1_KEY, C1_CT);
    wait_acc();
    bus.in_valid = 1'b0;
    repeat ((LAT - 1 < 4) ? LAT - 1 : 4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(bus.out_valid), 128'd0);
    check("arst_out", bus.out, 128'h0);
    check("arst_busy", 128'(bus.busy), 128'd0);
    exp_q.delete();
    ov_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(C1_PT, C1_KEY, C1_CT);
    wait_acc();
    bus.in_valid = 1'b0;
    wait_out();
    check("post_rst_latency", 128'(rise_cyc - acc_cyc), 128'(LAT + 1));
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
